// File: rtl/exec_sched_pkg.sv
// ==========================================================================
// Module  : exec_sched_pkg
// Desc    : Op class encodings and default sizing for the issue scheduler.
// Rev     : 1.0 - initial release
// ==========================================================================
`default_nettype none

package exec_sched_pkg;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'b00,
      CLS_MUL  = 2'b01,
      CLS_LDST = 2'b10,
      CLS_NOP  = 2'b11
   } op_cls_e;

   localparam int DEF_IDX_W    = 6;
   localparam int DEF_MULT_LAT = 4;

endpackage : exec_sched_pkg

`default_nettype wire

// File: rtl/exec_sched_rr_arb2.sv
// ==========================================================================
// Module  : rr_arb2
// Desc    : Two-requester round-robin arbiter; pointer names the lane that
//           wins a tie and moves to the losing side after every grant.
// Rev     : 1.0 - initial release
// ==========================================================================
`default_nettype none

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   output logic [1:0] o_gnt
);

   logic r_ptr;

   always_comb begin
      o_gnt = 2'b00;
      if (&i_req)
         o_gnt = r_ptr ? 2'b10 : 2'b01;
      else
         o_gnt = i_req;
   end

   // Pointer lands on the lane that was not served.
   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= 1'b0;
      else if (i_upd && (|o_gnt))
         r_ptr <= o_gnt[0];
   end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/exec_sched.sv
// ==========================================================================
// Module  : exec_sched
// Desc    : Two-lane issue scheduler steering ops onto ALU pair, multiplier
//           and address adder, with multiply occupancy / write-back tracking.
// Rev     : 1.0 - initial release
// ==========================================================================
`default_nettype none

module exec_sched
   import exec_sched_pkg::*;
#(
   parameter int IDX_W    = DEF_IDX_W,
   parameter int MULT_LAT = DEF_MULT_LAT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lane0_vld,
   input  logic [1:0]       lane0_cls,
   input  logic [IDX_W-1:0] lane0_indx,
   input  logic             lane1_vld,
   input  logic [1:0]       lane1_cls,
   input  logic [IDX_W-1:0] lane1_indx,
   input  logic             mult_free,
   output logic             lane0_gnt,
   output logic             lane1_gnt,
   output logic             alu1_en,
   output logic             alu2_en,
   output logic             mult_en,
   output logic             addr_en,
   output logic             mult_sel,
   output logic             addr_sel,
   output logic [IDX_W-1:0] alu1_indx,
   output logic [IDX_W-1:0] alu2_indx,
   output logic [IDX_W-1:0] addr_indx,
   output logic             mult_wb_vld,
   output logic [IDX_W-1:0] mult_wb_indx
);

   localparam int CNT_W = $clog2(MULT_LAT + 1);
   localparam logic [CNT_W-1:0] c_cnt_lat  = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_zero = '0;

   logic             w_live;
   logic             w_alu0;
   logic             w_alu1;
   logic             w_nop0;
   logic             w_nop1;
   logic             w_mul_avail;
   logic [1:0]       w_mul_req;
   logic [1:0]       w_mul_gnt;
   logic [1:0]       w_addr_req;
   logic [1:0]       w_addr_gnt;
   logic             w_mul_any;
   logic             w_addr_any;

   logic             r_alu1_en;
   logic             r_alu2_en;
   logic             r_mult_en;
   logic             r_addr_en;
   logic             r_mult_sel;
   logic             r_addr_sel;
   logic [IDX_W-1:0] r_alu1_indx;
   logic [IDX_W-1:0] r_alu2_indx;
   logic [IDX_W-1:0] r_addr_indx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wb_vld;
   logic [IDX_W-1:0] r_wb_indx;

   // Reset suppresses every grant so nothing is consumed while it is held.
   assign w_live = ~rst;

   assign w_alu0 = w_live && lane0_vld && (lane0_cls == CLS_ALU);
   assign w_alu1 = w_live && lane1_vld && (lane1_cls == CLS_ALU);
   assign w_nop0 = w_live && lane0_vld && (lane0_cls == CLS_NOP);
   assign w_nop1 = w_live && lane1_vld && (lane1_cls == CLS_NOP);

   assign w_mul_avail = (r_cnt == c_cnt_zero) && mult_free;

   assign w_mul_req[0]  = w_live && w_mul_avail && lane0_vld && (lane0_cls == CLS_MUL);
   assign w_mul_req[1]  = w_live && w_mul_avail && lane1_vld && (lane1_cls == CLS_MUL);
   assign w_addr_req[0] = w_live && lane0_vld && (lane0_cls == CLS_LDST);
   assign w_addr_req[1] = w_live && lane1_vld && (lane1_cls == CLS_LDST);

   rr_arb2 u_mul_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_mul_req),
      .i_upd (w_live),
      .o_gnt (w_mul_gnt)
   );

   rr_arb2 u_addr_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_addr_req),
      .i_upd (w_live),
      .o_gnt (w_addr_gnt)
   );

   assign w_mul_any  = |w_mul_gnt;
   assign w_addr_any = |w_addr_gnt;

   assign lane0_gnt = w_alu0 | w_nop0 | w_mul_gnt[0] | w_addr_gnt[0];
   assign lane1_gnt = w_alu1 | w_nop1 | w_mul_gnt[1] | w_addr_gnt[1];

   // Unit enables: one-cycle echo of this cycle's grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu1_en <= 1'b0;
         r_alu2_en <= 1'b0;
         r_mult_en <= 1'b0;
         r_addr_en <= 1'b0;
      end else begin
         r_alu1_en <= w_alu0;
         r_alu2_en <= w_alu1;
         r_mult_en <= w_mul_any;
         r_addr_en <= w_addr_any;
      end
   end

   // Operand select and index registers hold their last granted value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu1_indx <= '0;
         r_alu2_indx <= '0;
         r_addr_indx <= '0;
         r_addr_sel  <= 1'b0;
         r_mult_sel  <= 1'b0;
      end else begin
         if (w_alu0)
            r_alu1_indx <= lane0_indx;
         if (w_alu1)
            r_alu2_indx <= lane1_indx;
         if (w_addr_any) begin
            r_addr_sel  <= w_addr_gnt[1];
            r_addr_indx <= w_addr_gnt[1] ? lane1_indx : lane0_indx;
         end
         if (w_mul_any)
            r_mult_sel <= w_mul_gnt[1];
      end
   end

   // Multiply tracker: cnt reaching zero lines up with the write-back pulse,
   // which is also the earliest cycle a follow-on multiply can be granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= c_cnt_zero;
         r_wb_vld  <= 1'b0;
         r_wb_indx <= '0;
      end else begin
         r_wb_vld <= (r_cnt == c_cnt_one);
         if (w_mul_any) begin
            r_cnt     <= c_cnt_lat;
            r_wb_indx <= w_mul_gnt[1] ? lane1_indx : lane0_indx;
         end else if (r_cnt != c_cnt_zero) begin
            r_cnt <= r_cnt - c_cnt_one;
         end
      end
   end

   assign alu1_en      = r_alu1_en;
   assign alu2_en      = r_alu2_en;
   assign mult_en      = r_mult_en;
   assign addr_en      = r_addr_en;
   assign mult_sel     = r_mult_sel;
   assign addr_sel     = r_addr_sel;
   assign alu1_indx    = r_alu1_indx;
   assign alu2_indx    = r_alu2_indx;
   assign addr_indx    = r_addr_indx;
   assign mult_wb_vld  = r_wb_vld;
   assign mult_wb_indx = r_wb_indx;

endmodule : exec_sched

`default_nettype wire

// File: tb/tb_exec_sched.sv
// ==========================================================================
// Module  : tb_exec_sched
// Desc    : Self-checking bench for exec_sched: directed scenarios plus
//           randomized traffic against a cycle-stamped behavioural model.
// Rev     : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_exec_sched;
   import exec_sched_pkg::*;

   localparam int IDX_W    = 6;
   localparam int MULT_LAT = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             lane0_vld = 1'b0, lane1_vld = 1'b0;
   logic [1:0]       lane0_cls = 2'b00, lane1_cls = 2'b00;
   logic [IDX_W-1:0] lane0_indx = '0, lane1_indx = '0;
   logic             mult_free = 1'b1;
   logic             lane0_gnt, lane1_gnt;
   logic             alu1_en, alu2_en, mult_en, addr_en, mult_sel, addr_sel;
   logic [IDX_W-1:0] alu1_indx, alu2_indx, addr_indx, mult_wb_indx;
   logic             mult_wb_vld;

   int n_checks = 0;
   int n_errors = 0;

   exec_sched #(.IDX_W(IDX_W), .MULT_LAT(MULT_LAT)) dut (
      .clk(clk), .rst(rst),
      .lane0_vld(lane0_vld), .lane0_cls(lane0_cls), .lane0_indx(lane0_indx),
      .lane1_vld(lane1_vld), .lane1_cls(lane1_cls), .lane1_indx(lane1_indx),
      .mult_free(mult_free),
      .lane0_gnt(lane0_gnt), .lane1_gnt(lane1_gnt),
      .alu1_en(alu1_en), .alu2_en(alu2_en), .mult_en(mult_en), .addr_en(addr_en),
      .mult_sel(mult_sel), .addr_sel(addr_sel),
      .alu1_indx(alu1_indx), .alu2_indx(alu2_indx), .addr_indx(addr_indx),
      .mult_wb_vld(mult_wb_vld), .mult_wb_indx(mult_wb_indx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (cycle-stamped) ----------------
   int               cyc = 0;
   int               mul_ready_cyc = 0;
   bit               wb_pend = 0;
   int               wb_cyc = 0;
   logic [IDX_W-1:0] m_wb_indx = '0;
   bit               ptr_mul = 0, ptr_addr = 0;
   bit               e_alu1_en = 0, e_alu2_en = 0, e_mult_en = 0, e_addr_en = 0;
   bit               e_mult_sel = 0, e_addr_sel = 0;
   logic [IDX_W-1:0] e_alu1_indx = '0, e_alu2_indx = '0, e_addr_indx = '0;

   function automatic int pick(input bit r0, input bit r1, input bit ptr);
      if (r0 && r1) return ptr ? 1 : 0;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   always @(negedge clk) begin
      int mw, aw;
      bit g0, g1, e_wb;
      mw = -1;
      aw = -1;
      if (!rst) begin
         if (cyc >= mul_ready_cyc && mult_free)
            mw = pick(lane0_vld && lane0_cls == CLS_MUL, lane1_vld && lane1_cls == CLS_MUL, ptr_mul);
         aw = pick(lane0_vld && lane0_cls == CLS_LDST, lane1_vld && lane1_cls == CLS_LDST, ptr_addr);
      end
      g0 = !rst && lane0_vld && (lane0_cls == CLS_ALU || lane0_cls == CLS_NOP ||
                                 (lane0_cls == CLS_MUL && mw == 0) || (lane0_cls == CLS_LDST && aw == 0));
      g1 = !rst && lane1_vld && (lane1_cls == CLS_ALU || lane1_cls == CLS_NOP ||
                                 (lane1_cls == CLS_MUL && mw == 1) || (lane1_cls == CLS_LDST && aw == 1));
      e_wb = wb_pend && (wb_cyc == cyc);

      check("lane0_gnt", 32'(lane0_gnt), 32'(g0));
      check("lane1_gnt", 32'(lane1_gnt), 32'(g1));
      check("alu1_en", 32'(alu1_en), 32'(e_alu1_en));
      check("alu2_en", 32'(alu2_en), 32'(e_alu2_en));
      check("mult_en", 32'(mult_en), 32'(e_mult_en));
      check("addr_en", 32'(addr_en), 32'(e_addr_en));
      check("mult_sel", 32'(mult_sel), 32'(e_mult_sel));
      check("addr_sel", 32'(addr_sel), 32'(e_addr_sel));
      check("alu1_indx", 32'(alu1_indx), 32'(e_alu1_indx));
      check("alu2_indx", 32'(alu2_indx), 32'(e_alu2_indx));
      check("addr_indx", 32'(addr_indx), 32'(e_addr_indx));
      check("mult_wb_vld", 32'(mult_wb_vld), 32'(e_wb));
      if (e_wb) begin
         check("mult_wb_indx", 32'(mult_wb_indx), 32'(m_wb_indx));
         wb_pend = 0;
      end

      if (rst) begin
         {e_alu1_en, e_alu2_en, e_mult_en, e_addr_en, e_mult_sel, e_addr_sel} = '0;
         e_alu1_indx = '0; e_alu2_indx = '0; e_addr_indx = '0;
         ptr_mul = 0; ptr_addr = 0;
         wb_pend = 0; m_wb_indx = '0; mul_ready_cyc = 0;
      end else begin
         e_alu1_en = g0 && lane0_cls == CLS_ALU;
         e_alu2_en = g1 && lane1_cls == CLS_ALU;
         if (e_alu1_en) e_alu1_indx = lane0_indx;
         if (e_alu2_en) e_alu2_indx = lane1_indx;
         e_addr_en = (aw >= 0);
         if (aw >= 0) begin
            e_addr_sel  = (aw == 1);
            e_addr_indx = (aw == 1) ? lane1_indx : lane0_indx;
            ptr_addr    = (aw == 0);
         end
         e_mult_en = (mw >= 0);
         if (mw >= 0) begin
            e_mult_sel    = (mw == 1);
            m_wb_indx     = (mw == 1) ? lane1_indx : lane0_indx;
            wb_pend       = 1;
            wb_cyc        = cyc + 1 + MULT_LAT;
            mul_ready_cyc = cyc + 1 + MULT_LAT;
            ptr_mul       = (mw == 0);
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v0, input logic [1:0] c0, input int i0,
                        input bit v1, input logic [1:0] c1, input int i1, input bit mf);
      @(posedge clk);
      #1;
      rst = 1'b0;
      lane0_vld = v0; lane0_cls = c0; lane0_indx = IDX_W'(i0);
      lane1_vld = v1; lane1_cls = c1; lane1_indx = IDX_W'(i1);
      mult_free = mf;
      #2;
   endtask

   task automatic reset_cycle();
      @(posedge clk);
      #1;
      rst = 1'b1;
      lane0_vld = 1'b0; lane1_vld = 1'b0; mult_free = 1'b1;
      #2;
   endtask

   task automatic idle();
      drive(0, CLS_NOP, 0, 0, CLS_NOP, 0, 1);
   endtask

   initial begin
      reset_cycle();
      reset_cycle();
      idle();
      check("lit_rst_alu1_en", 32'(alu1_en), 32'd0);
      check("lit_rst_mult_en", 32'(mult_en), 32'd0);
      check("lit_rst_wb_vld", 32'(mult_wb_vld), 32'd0);
      check("lit_rst_gnt", 32'({lane0_gnt, lane1_gnt}), 32'd0);

      // ALU pair
      drive(1, CLS_ALU, 5, 1, CLS_ALU, 9, 1);
      check("lit_alu_gnt", 32'({lane0_gnt, lane1_gnt}), 32'b11);
      idle();
      check("lit_alu1", 32'({alu1_en, alu1_indx}), {25'd0, 1'b1, 6'd5});
      check("lit_alu2", 32'({alu2_en, alu2_indx}), {25'd0, 1'b1, 6'd9});

      // LDST contention alternates
      for (int k = 0; k < 3; k++) begin
         drive(1, CLS_LDST, 3, 1, CLS_LDST, 4, 1);
         check($sformatf("lit_ldst_gnt%0d", k), 32'({lane0_gnt, lane1_gnt}), (k == 1) ? 32'b01 : 32'b10);
         if (k > 0)
            check($sformatf("lit_ldst_sel%0d", k - 1), 32'(addr_sel), (k == 2) ? 32'd1 : 32'd0);
      end
      idle();
      check("lit_ldst_sel2", 32'({addr_en, addr_sel, addr_indx}), {24'd0, 2'b10, 6'd3});

      // Multiply occupancy and write-back alignment
      drive(1, CLS_MUL, 12, 1, CLS_MUL, 20, 1);
      check("lit_mul_gnt", 32'({lane0_gnt, lane1_gnt}), 32'b10);
      for (int k = 1; k <= 5; k++) begin
         drive(0, CLS_NOP, 0, 1, CLS_MUL, 20, 1);
         check($sformatf("lit_mul_l1gnt_t%0d", k), 32'(lane1_gnt), (k == 5) ? 32'd1 : 32'd0);
         check($sformatf("lit_mul_wb_t%0d", k), 32'(mult_wb_vld), (k == 5) ? 32'd1 : 32'd0);
         if (k == 1) check("lit_mul_en", 32'({mult_en, mult_sel}), 32'b10);
         if (k == 5) check("lit_mul_wb_indx", 32'(mult_wb_indx), 32'd12);
      end
      idle();
      check("lit_mul2_en", 32'({mult_en, mult_sel, mult_wb_vld}), 32'b110);

      // mult_free gating, NOP alongside busy multiplier, pointer handoff
      reset_cycle();
      for (int k = 0; k < 2; k++) begin
         drive(1, CLS_MUL, 7, 1, CLS_MUL, 8, 0);
         check($sformatf("lit_nofree_gnt%0d", k), 32'({lane0_gnt, lane1_gnt}), 32'b00);
      end
      drive(1, CLS_MUL, 7, 1, CLS_MUL, 8, 1);
      check("lit_free_gnt", 32'({lane0_gnt, lane1_gnt}), 32'b10);
      drive(1, CLS_NOP, 0, 1, CLS_MUL, 8, 1);
      check("lit_nop_gnt", 32'({lane0_gnt, lane1_gnt}), 32'b10);
      idle();
      check("lit_nop_no_en", 32'({alu1_en, alu2_en, mult_en, addr_en}), 32'd0);
      for (int k = 3; k <= 5; k++) begin
         drive(1, CLS_MUL, 7, 1, CLS_MUL, 8, 1);
         check($sformatf("lit_slot_gnt%0d", k), 32'({lane0_gnt, lane1_gnt}), (k == 5) ? 32'b01 : 32'b00);
      end
      check("lit_slot_wb", 32'({mult_wb_vld, mult_wb_indx}), {25'd0, 1'b1, 6'd7});

      // Reset with cnt==2 abandons the multiply
      idle();
      idle();
      reset_cycle();
      for (int k = 0; k < 5; k++) begin
         idle();
         check($sformatf("lit_abandon_wb%0d", k), 32'(mult_wb_vld), 32'd0);
      end

      // Randomized traffic, checked every cycle by the model process
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         rst        = ($urandom_range(0, 63) == 0);
         lane0_vld  = ($urandom_range(0, 3) != 0);
         lane1_vld  = ($urandom_range(0, 3) != 0);
         lane0_cls  = 2'($urandom_range(0, 3));
         lane1_cls  = 2'($urandom_range(0, 3));
         lane0_indx = IDX_W'($urandom);
         lane1_indx = IDX_W'($urandom);
         mult_free  = ($urandom_range(0, 7) != 0);
      end
      idle();
      idle();
      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_exec_sched

`default_nettype wire

// File: doc/exec_sched.md
# exec_sched

Issue scheduler for the execution stage. Takes up to two ready operations per cycle from the dispatch lanes and steers them onto the ALU pair, the single multiplier and the single address adder. It arbitrates the shared units round-robin and tracks the multi-cycle multiplier occupancy. It returns the in-flight multiply's instruction index aligned with the multiplier's write-back pulse. It sits between the dispatch/issue queue and the execution top level, and drives that level's unit enables and operand-select lines.

## Interface
- IDX_W, 6, width of instruction index
- MULT_LAT, 4, cycles from mult_en high to multiplier result valid (≥1)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lane0_vld, lane1_vld  in  1  lane holds an issuable op
- lane0_cls, lane1_cls  in  2  op class: 00 ALU, 01 MUL, 10 LDST, 11 NOP
- lane0_indx, lane1_indx  in  IDX_W  op index
- mult_free  in  1  multiplier reports idle
- lane0_gnt, lane1_gnt  out  1  combinational; op consumed this cycle
- alu1_en, alu2_en, mult_en, addr_en  out  1  registered unit enables
- mult_sel, addr_sel  out  1  registered; source lane of operands (0/1)
- alu1_indx, alu2_indx, addr_indx  out  IDX_W  registered index travelling with each enable
- mult_wb_vld  out  1  one-cycle pulse, multiply result writing back
- mult_wb_indx  out  IDX_W  index of that result, valid while mult_wb_vld

## Operation
- ALU: lane0 ALU → alu1, lane1 ALU → alu2. No contention, so the op is always granted when valid.
- NOP (11): always granted, no unit enabled.
- MUL is available when cnt==0 and mult_free.
  - One MUL requester + available → grant.
  - Two requesters → the rr_mul pointer lane wins.
  - Unavailable → no MUL grant.
- LDST: single addr unit; two requesters → the rr_addr pointer lane wins. Always available.
- Pointer update: on any grant of that unit, the pointer moves to the other lane. Reset value: lane0.
- Loser is not granted and re-presents next cycle; scheduler holds no op state.
- Registered outputs update every cycle. An enable is 1 the cycle after a grant to that unit, else 0. Index/sel registers load only on grant and hold otherwise.
- Multiply tracker:
  - cnt (width ceil(log2(MULT_LAT+1))) loads MULT_LAT on MUL grant, decrements while nonzero.
  - wb_indx latches the granted index.
  - mult_wb_vld = 1 in the cycle after cnt goes 1→0.
- Reset: all enables, mult_wb_vld, cnt and pointers go to 0; index/sel outputs go to 0. An in-flight multiply is abandoned: no wb pulse and its index is lost.
- Reset has priority over a grant presented in the same cycle.

## Timing
- Grant in cycle T (comb from inputs and state) → unit enable, sel and indx in T+1.
- MUL granted in T → mult_en in T+1 → mult_wb_vld and mult_wb_indx in T+1+MULT_LAT.
- cnt==0 in the wb cycle, so a new MUL may be granted in T+1+MULT_LAT (earliest). This gives a next mult_en at T+2+MULT_LAT; there is no overlap.
- mult_free low overrides cnt==0; no grant until it returns high.
- Both lanes MUL or both LDST: exactly one gnt; the other lane's gnt=0.
- Lanes with different classes are granted independently in the same cycle.

## Structure
- Package exec_sched_pkg holds:
  - class encodings CLS_ALU/CLS_MUL/CLS_LDST/CLS_NOP
  - default IDX_W and MULT_LAT
- Sub-module rr_arb2: two-request round-robin arbiter with pointer register, sync reset and an update-on-grant input. Instantiated twice (MUL and LDST).
- The multiply tracker (cnt, wb_indx, wb pulse) stays inline.

## Test plan
- Reset then idle → all enables 0, mult_wb_vld 0, gnts 0. Assert rst mid-multiply (cnt=2) → no wb pulse follows.
- lane0 ALU indx 5 and lane1 ALU indx 9 → both gnt in T. In T+1: alu1_en=1, alu1_indx=5, alu2_en=1, alu2_indx=9.
- Both lanes LDST (indx 3, 4) held for 3 cycles → gnts alternate lane0, lane1, lane0. addr_sel follows 0, 1, 0 one cycle later.
- lane0 MUL indx 12 at T, MULT_LAT=4 → mult_en at T+1; mult_wb_vld=1 and mult_wb_indx=12 at T+5 only. lane1 MUL held meanwhile is denied T..T+4 and granted at T+5.
- Both lanes MUL, mult_free=0 → no gnt. mult_free=1 → pointer lane (lane0 after reset) granted; the next free slot goes to lane1.
- lane0 NOP + lane1 MUL with cnt≠0 → lane0_gnt=1, lane1_gnt=0; no enables.
